// File: rtl/mips32_pkg.sv
// Shared constants and types for the pipe_MIPS32 core.
package mips32_pkg;

  // Instruction memory geometry and boot address
  localparam int unsigned MIPS_AW       = 10;
  localparam int unsigned MIPS_RESET_PC = 0;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

  // Instruction type codes
  localparam logic [2:0] TYPE_RR_ALU = 3'd0;
  localparam logic [2:0] TYPE_RM_ALU = 3'd1;
  localparam logic [2:0] TYPE_LOAD   = 3'd2;
  localparam logic [2:0] TYPE_STORE  = 3'd3;
  localparam logic [2:0] TYPE_BRANCH = 3'd4;
  localparam logic [2:0] TYPE_HALT   = 3'd5;

  // Fetch-queue control states
  typedef enum logic [1:0] {
    FQ_RUN   = 2'd0,
    FQ_DRAIN = 2'd1,
    FQ_STOP  = 2'd2
  } fq_state_t;

  // Classify an opcode into its pipeline type code
  function automatic logic [2:0] instr_type(input logic [5:0] op);
    logic [2:0] t;
    t = TYPE_HALT;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = TYPE_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = TYPE_RM_ALU;
      OP_LW:                                         t = TYPE_LOAD;
      OP_SW:                                         t = TYPE_STORE;
      OP_BNEQZ, OP_BEQZ:                             t = TYPE_BRANCH;
      default:                                       t = TYPE_HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// Same-cycle push and pop is allowed (also when full); flush wins over both.
module mips32_sync_fifo
  import mips32_pkg::*;
#(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk1) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: fetches words over req/ack into a queue and
// hands {IR, NPC} pairs to ID. Flushes on redirect, freezes on halt.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = MIPS_AW,
  parameter int unsigned RESET_PC = MIPS_RESET_PC
) (
  input  logic                   clk1,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  input  logic                   halt,
  output logic                   id_valid,
  output logic [31:0]            id_ir,
  output logic [31:0]            id_npc,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned   CW  = $clog2(DEPTH) + 1;
  localparam int unsigned   EW  = 32 + AW;
  localparam logic [AW-1:0] PC0 = AW'(RESET_PC);

  fq_state_t     state, state_nx;
  logic [AW-1:0] fetch_pc, fetch_pc_nx;
  logic [AW-1:0] target_pc, target_nx;
  logic [AW-1:0] addr_nx;
  logic [AW-1:0] pc_inc;
  logic          req_nx;
  logic          halt_q;
  logic          halt_now;
  logic          ack;
  logic          wait_ack;
  logic          push;
  logic          pop;
  logic          flush;
  logic          room;
  logic [CW-1:0] count_nx;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;

  assign ack      = imem_req & imem_ack;
  assign wait_ack = imem_req & ~imem_ack;
  assign pop      = id_valid & id_ready;
  assign halt_now = halt | halt_q;
  assign pc_inc   = fetch_pc + 1'b1;

  // Acked data is only kept in RUN without a redirect; STOP ignores redirects
  assign push     = (state == FQ_RUN) & ~redirect_valid & ack;
  assign flush    = redirect_valid & (state != FQ_STOP);
  assign count_nx = count + CW'(push) - CW'(pop);
  assign room     = (count_nx < CW'(DEPTH));

  assign id_valid = ~fifo_empty;
  assign id_ir    = head[EW-1:AW];
  assign id_npc   = 32'(head[AW-1:0]);

  mips32_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({imem_rdata, pc_inc}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Next-state, fetch pointer and issue decision
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    target_nx   = target_pc;
    req_nx      = imem_req;
    addr_nx     = imem_addr;
    case (state)
      FQ_RUN: begin
        if (redirect_valid) begin
          if (wait_ack) begin
            // Outstanding request must finish on its old address first
            state_nx  = FQ_DRAIN;
            target_nx = redirect_pc;
          end else begin
            fetch_pc_nx = redirect_pc;
            addr_nx     = redirect_pc;
            if (halt_now) begin
              state_nx = FQ_STOP;
              req_nx   = 1'b0;
            end else begin
              req_nx = 1'b1;
            end
          end
        end else begin
          if (ack) fetch_pc_nx = pc_inc;
          if (!wait_ack) begin
            if (halt_now) begin
              state_nx = FQ_STOP;
              req_nx   = 1'b0;
            end else begin
              req_nx  = room;
              addr_nx = ack ? pc_inc : fetch_pc;
            end
          end
        end
      end
      FQ_DRAIN: begin
        if (redirect_valid) target_nx = redirect_pc;
        if (ack) begin
          // Latest target wins, including one arriving with the ack
          fetch_pc_nx = redirect_valid ? redirect_pc : target_pc;
          addr_nx     = fetch_pc_nx;
          if (halt_now) begin
            state_nx = FQ_STOP;
            req_nx   = 1'b0;
          end else begin
            state_nx = FQ_RUN;
            req_nx   = room;
          end
        end
      end
      FQ_STOP: begin
        req_nx = 1'b0;
      end
      default: begin
        state_nx = FQ_RUN;
        req_nx   = 1'b0;
      end
    endcase
  end

  // Control and request registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= FQ_RUN;
      fetch_pc  <= PC0;
      target_pc <= PC0;
      imem_req  <= 1'b0;
      imem_addr <= PC0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      target_pc <= target_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
    end
  end

  // Sticky halt flag
  always_ff @(posedge clk1) begin
    if (rst)       halt_q <= 1'b0;
    else if (halt) halt_q <= 1'b1;
  end

  a_no_full_with_req: assert property (@(posedge clk1) disable iff (rst)
    !(fifo_full && imem_req));

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue: memory responder, reference model
// feeding an expected-entry queue, and a monitor comparing ID transfers.
module tb_mips32_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned MSIZE = 1 << AW;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          id_valid;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic          id_ready;
  logic [2:0]    count;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (0)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_ir          (id_ir),
    .id_npc         (id_npc),
    .id_ready       (id_ready),
    .count          (count)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [MSIZE];
  entry_t      sb[$];
  int          lat_mode = 0;   // <0: random 0..3 wait cycles
  bit          started = 0;
  int unsigned ack_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: random or fixed wait states per request
  int wait_cnt = 0;
  bit busy = 0;
  always @(negedge clk1) begin
    imem_ack = 1'b0;
    if (rst || !imem_req) begin
      busy = 0;
    end else begin
      if (!busy) begin
        busy     = 1;
        wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        busy       = 0;
      end else begin
        wait_cnt--;
      end
    end
  end

  // Reference model and ID-side monitor
  int unsigned exp_pc = 0;
  int unsigned tgt = 0;
  bit draining = 0, halted = 0, stopped = 0;
  bit req_prev = 0, ack_prev = 0;
  logic [AW-1:0] addr_prev = '0;

  always @(posedge clk1) begin
    bit     a, w, new_req;
    entry_t e;
    if (rst) begin
      sb.delete();
      exp_pc = 0; draining = 0; halted = 0; stopped = 0;
      req_prev = 0; ack_prev = 0;
      started = 1;
    end else if (started) begin
      a = imem_req && imem_ack;
      w = imem_req && !imem_ack;
      if (req_prev && !ack_prev) begin
        check("req_hold", imem_req, 1);
        check("addr_hold", imem_addr, addr_prev);
      end
      new_req = imem_req && !(req_prev && !ack_prev);
      if (halted) check("req_after_halt", new_req, 0);
      if (id_valid && id_ready) begin
        check("pop_when_sb_empty", sb.size() == 0, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("id_ir", id_ir, e.ir);
          check("id_npc", id_npc, e.npc);
        end
      end
      if (redirect_valid && !stopped) begin
        sb.delete();
        if (draining) begin
          if (a) begin draining = 0; exp_pc = redirect_pc; end
          else tgt = redirect_pc;
        end else if (w) begin
          draining = 1; tgt = redirect_pc;
        end else begin
          exp_pc = redirect_pc;
        end
      end else if (a) begin
        if (draining) begin
          draining = 0; exp_pc = tgt;
        end else begin
          check("imem_addr", imem_addr, exp_pc);
          e.ir  = mem[exp_pc];
          e.npc = (exp_pc + 1) % MSIZE;
          sb.push_back(e);
          exp_pc = (exp_pc + 1) % MSIZE;
          ack_total++;
        end
      end
      if (halt) halted = 1;
      if (halted && !w && !draining) stopped = 1;
      req_prev  = imem_req;
      ack_prev  = a;
      addr_prev = imem_addr;
    end
  end

  // Occupancy must match the model every cycle
  always @(negedge clk1) begin
    if (started && !rst) begin
      check("count", count, sb.size());
      check("id_valid", id_valid, sb.size() != 0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk1); #1; end
  endtask

  task automatic do_reset();
    id_ready = 0; redirect_valid = 0; halt = 0; rst = 1;
    step(2);
    rst = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int unsigned a0;
    for (int unsigned i = 0; i < MSIZE; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
    imem_ack = 0; imem_rdata = '0; redirect_pc = '0;
    redirect_valid = 0; halt = 0; id_ready = 0;

    // 1: reset state, zero-wait streaming
    lat_mode = 0;
    rst = 1;
    step(2);
    check("rst_count", count, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    rst = 0; id_ready = 1;
    step();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, i);
      end
      if (i >= 1) begin
        check("t1_valid", id_valid, 1);
        check("t1_ir", id_ir, mem[i-1]);
        check("t1_npc", id_npc, i);
      end
      step();
    end
    step(3);

    // 2: backpressure fills the queue; one pop allows exactly one fetch
    do_reset();
    lat_mode = 0;
    step(8);
    check("t2_full_count", count, 4);
    check("t2_full_req", imem_req, 0);
    a0 = ack_total;
    id_ready = 1; step(); id_ready = 0;
    step(4);
    check("t2_one_fetch", ack_total - a0, 1);
    check("t2_count", count, 4);
    check("t2_req", imem_req, 0);

    // 3: redirect while a slow request is pending
    do_reset();
    lat_mode = 3; id_ready = 1;
    for (k = 0; k < 200 && !(imem_req && imem_addr == 5); k++) step();
    check("t3_reach_addr5", imem_req && imem_addr == 5, 1);
    step();
    redirect_valid = 1; redirect_pc = 200;
    step();
    redirect_valid = 0;
    check("t3_flushed", count, 0);
    check("t3_addr_held", imem_addr, 5);
    check("t3_req_held", imem_req, 1);
    for (k = 0; k < 20 && !(imem_req && imem_addr == 200); k++) step();
    check("t3_new_addr", imem_req && imem_addr == 200, 1);
    step(12);

    // 4: redirect coinciding with ack and pop at count=2
    do_reset();
    lat_mode = 0;
    for (k = 0; k < 20 && count != 2; k++) step();
    check("t4_setup", count == 2 && imem_req && imem_ack, 1);
    id_ready = 1; redirect_valid = 1; redirect_pc = 300;
    step();
    redirect_valid = 0; id_ready = 0;
    check("t4_count", count, 0);
    check("t4_valid", id_valid, 0);
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 300);
    id_ready = 1;
    step(6);

    // 5: halt with two queued and one pending
    do_reset();
    lat_mode = 3;
    for (k = 0; k < 40 && !(count == 2 && imem_req && !imem_ack); k++) step();
    check("t5_setup", count == 2 && imem_req && !imem_ack, 1);
    halt = 1; step(); halt = 0;
    step(8);
    check("t5_count", count, 3);
    check("t5_req", imem_req, 0);
    id_ready = 1;
    step(5);
    check("t5_drained", count, 0);
    check("t5_valid", id_valid, 0);
    redirect_valid = 1; redirect_pc = 100;
    step();
    redirect_valid = 0;
    step(4);
    check("t5_redir_ignored_req", imem_req, 0);
    check("t5_redir_ignored_count", count, 0);

    // 6: address wrap, then reset in the middle of a drain
    do_reset();
    lat_mode = 0; id_ready = 1;
    step(2);
    redirect_valid = 1; redirect_pc = 1022;
    step();
    redirect_valid = 0;
    check("t6_addr0", imem_addr, 1022);
    step();
    check("t6_addr1", imem_addr, 1023);
    step();
    check("t6_addr2", imem_addr, 0);
    step(4);
    lat_mode = 3;
    for (k = 0; k < 20 && !(imem_req && !imem_ack); k++) step();
    check("t6_pending", imem_req && !imem_ack, 1);
    redirect_valid = 1; redirect_pc = 50;
    step();
    redirect_valid = 0;
    rst = 1;
    step();
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_addr", imem_addr, 0);
    check("t6_rst_count", count, 0);
    rst = 0;

    // Randomized traffic against the model
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = AW'($urandom_range(0, MSIZE - 1));
      step();
    end
    redirect_valid = 0; id_ready = 1;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
